// File: rtl/hram_uart_cmd_bridge_pkg.sv
// Command codes, response constants and TX FSM encoding shared by the UART-to-HyperRAM bridge.
// Optional checksum framing is selected with the HRAM_CMD_CKSUM_EN macro in the top module.
package hram_uart_cmd_bridge_pkg;

    localparam logic [7:0] CMD_ADDR   = 8'h01;
    localparam logic [7:0] CMD_LOAD   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_READ   = 8'h04;
    localparam logic [7:0] CMD_RDREQ  = 8'h05;
    localparam logic [7:0] CMD_COUNT  = 8'h06;
    localparam logic [7:0] CMD_CONST  = 8'h07;
    localparam logic [7:0] CMD_BURST  = 8'h08;
    localparam logic [7:0] CMD_STATUS = 8'h09;

    localparam logic [7:0]  NAK_BYTE  = 8'hEE;
    localparam int unsigned CONST_VAL = 259;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_START   = 2'd1,
        TX_WAIT_LO = 2'd2,
        TX_WAIT_HI = 2'd3
    } tx_state_t;

endpackage

// File: rtl/hram_resp_fifo.sv
// Response FIFO, DW x DEPTH words, first-word fall-through read port.
// A push while full succeeds only when a pop happens in the same cycle.
module hram_resp_fifo #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_c     = (level_q == LW'(DEPTH));
    assign empty_c    = (level_q == '0);
    assign pop_data_c = mem_q[rd_ptr_q];
    assign level      = level_q;

    always_comb begin
        do_pop   = pop && !empty_c;
        do_push  = push && (!full_c || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        level_d  = level_q + LW'(do_push) - LW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/hram_uart_cmd_bridge.sv
// UART-to-HyperRAM command bridge: frames RX bytes into commands, drives memory requests and
// streams FIFO'd response words MSB first. Define HRAM_CMD_CKSUM_EN for XOR-checksummed framing.
module hram_uart_cmd_bridge
    import hram_uart_cmd_bridge_pkg::*;
#(
    parameter int unsigned DW             = 32,
    parameter int unsigned DATA_BYTES     = DW / 8,
    parameter int unsigned RESP_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 24000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx_rcv,
    input  logic [7:0]    rx_data,
    input  logic          tx_ready,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wr_d,
    output logic          mem_wr_req,
    output logic          mem_rd_req,
    output logic [5:0]    mem_rd_num,
    input  logic [DW-1:0] mem_rd_d,
    input  logic          mem_rd_rdy,
    input  logic          mem_busy,
    output logic [7:0]    err_count
);

`ifdef HRAM_CMD_CKSUM_EN
    localparam int unsigned CK_BYTES = 1;
`else
    localparam int unsigned CK_BYTES = 0;
`endif
    localparam int unsigned PW          = 8 * DATA_BYTES;
    localparam int unsigned FRAME_BYTES = 1 + DATA_BYTES + CK_BYTES;
    localparam int unsigned FW          = 8 * FRAME_BYTES;
    localparam int unsigned CW          = $clog2(FRAME_BYTES + 1);
    localparam int unsigned TOW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LW          = $clog2(RESP_DEPTH + 1);
    localparam int unsigned TX_BYTES    = DATA_BYTES + CK_BYTES;
    localparam int unsigned TXW         = 8 * TX_BYTES;
    localparam int unsigned BIW         = $clog2(TX_BYTES + 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [FW-1:0]  frame_q, frame_d;
    logic [TOW-1:0] to_q, to_d;
    logic           decode_q, decode_d, to_err;

    logic [31:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]  mem_wr_d_q, mem_wr_d_d;
    logic           mem_wr_req_q, mem_wr_req_d, mem_rd_req_q, mem_rd_req_d;
    logic [5:0]     mem_rd_num_q, mem_rd_num_d, left_q, left_d;
    logic [DW-1:0]  rd_word_q, rd_word_d, count_q, count_d, hold_q, hold_d;
    logic           burst_q, burst_d, hold_v_q, hold_v_d;
    logic [7:0]     err_count_q, err_count_d;

    tx_state_t      state_q, state_d;
    logic           tx_start_q, tx_start_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic [TXW-1:0] shift_q, shift_d, tx_word;
    logic [BIW-1:0] bidx_q, bidx_d;

    logic [7:0]     cmd;
    logic [PW-1:0]  payload;
    logic [5:0]     burst_n;
    logic           ck_bad, blk, nak, resp_v, resp_drop, burst_push, full_drop;
    logic [DW-1:0]  resp_w, push_w, fifo_rd_c;
    logic           push_v, pop, full_c, empty_c;
    logic [LW-1:0]  fifo_level;

    assign cmd     = frame_q[FW-1 -: 8];
    assign payload = frame_q[8*CK_BYTES +: PW];
    assign burst_n = payload[5:0];
    assign blk     = mem_busy || burst_q;

`ifdef HRAM_CMD_CKSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [DW-1:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int unsigned i = 0; i < DATA_BYTES; i++) x ^= w[8*i +: 8];
        return x;
    endfunction
    assign ck_bad  = ((xor_bytes(DW'(payload)) ^ cmd) != frame_q[7:0]);
    assign tx_word = {fifo_rd_c, xor_bytes(fifo_rd_c)};
`else
    assign ck_bad  = 1'b0;
    assign tx_word = TXW'(fifo_rd_c);
`endif

    // Byte framing with inter-byte timeout; decode fires the cycle after the last byte.
    always_comb begin
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        to_d     = '0;
        decode_d = 1'b0;
        to_err   = 1'b0;
        if (rx_rcv) begin
            frame_d = {frame_q[FW-9:0], rx_data};
            if (cnt_q == CW'(FRAME_BYTES - 1)) begin
                cnt_d    = '0;
                decode_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (cnt_q != '0) begin
            if (to_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                cnt_d  = '0;
                to_err = 1'b1;
            end else begin
                to_d = to_q + TOW'(1);
            end
        end
    end

    // Command execution, burst capture, response staging and error accounting.
    always_comb begin
        mem_addr_d   = mem_addr_q;
        mem_wr_d_d   = mem_wr_d_q;
        mem_wr_req_d = 1'b0;
        mem_rd_req_d = 1'b0;
        mem_rd_num_d = mem_rd_num_q;
        rd_word_d    = rd_word_q;
        count_d      = count_q;
        burst_d      = burst_q;
        left_d       = left_q;
        hold_d       = hold_q;
        hold_v_d     = hold_v_q;
        err_count_d  = err_count_q;
        nak          = 1'b0;
        resp_v       = 1'b0;
        resp_w       = '0;
        resp_drop    = 1'b0;
        burst_push   = 1'b0;
        if (mem_rd_rdy) begin
            rd_word_d = mem_rd_d;
            if (burst_q) begin
                burst_push = 1'b1;
                left_d     = left_q - 6'd1;
                if (left_q == 6'd1) burst_d = 1'b0;
            end
        end
        if (decode_q) begin
            if (ck_bad) begin
                nak = 1'b1;
            end else begin
                case (cmd)
                    CMD_ADDR:   begin mem_addr_d = 32'(payload); resp_v = 1'b1; resp_w = DW'(payload); end
                    CMD_LOAD:   begin mem_wr_d_d = DW'(payload); resp_v = 1'b1; resp_w = DW'(payload); end
                    CMD_WRITE: begin
                        if (blk) nak = 1'b1;
                        else begin mem_wr_req_d = 1'b1; resp_v = 1'b1; resp_w = DW'(3); end
                    end
                    CMD_READ:   begin resp_v = 1'b1; resp_w = rd_word_q; end
                    CMD_RDREQ: begin
                        if (blk) nak = 1'b1;
                        else begin
                            mem_rd_num_d = 6'd1;
                            mem_rd_req_d = 1'b1;
                            resp_v       = 1'b1;
                            resp_w       = DW'(5);
                        end
                    end
                    CMD_COUNT:  begin resp_v = 1'b1; resp_w = count_q; count_d = count_q + DW'(1); end
                    CMD_CONST:  begin resp_v = 1'b1; resp_w = DW'(CONST_VAL); end
                    CMD_BURST: begin
                        if (burst_n == 6'd0 || 32'(burst_n) > RESP_DEPTH || blk) nak = 1'b1;
                        else begin
                            mem_rd_num_d = burst_n;
                            mem_rd_req_d = 1'b1;
                            burst_d      = 1'b1;
                            left_d       = burst_n;
                        end
                    end
                    CMD_STATUS: begin
                        resp_v = 1'b1;
                        resp_w = DW'({err_count_q, fifo_level, burst_q, mem_busy});
                    end
                    default:    nak = 1'b1;
                endcase
            end
        end
        if (nak) begin
            resp_v = 1'b1;
            resp_w = DW'({DATA_BYTES{NAK_BYTE}});
        end
        // Burst words own the FIFO write port; a staged response waits one cycle behind them.
        push_v = burst_push || hold_v_q;
        push_w = burst_push ? mem_rd_d : hold_q;
        if (!burst_push) hold_v_d = 1'b0;
        if (resp_v) begin
            if (hold_v_d) resp_drop = 1'b1;
            else begin
                hold_d   = resp_w;
                hold_v_d = 1'b1;
            end
        end
        full_drop = push_v && full_c && !pop;
        if ((to_err || nak || resp_drop || full_drop) && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    // TX byte sequencer handshaking with uart_tx.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        shift_d    = shift_q;
        bidx_d     = bidx_q;
        pop        = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!empty_c && tx_ready) begin
                    pop        = 1'b1;
                    tx_data_d  = tx_word[TXW-1 -: 8];
                    shift_d    = tx_word << 8;
                    bidx_d     = BIW'(1);
                    tx_start_d = 1'b1;
                    state_d    = TX_START;
                end
            end
            TX_START:   state_d = TX_WAIT_LO;
            TX_WAIT_LO: if (!tx_ready) state_d = TX_WAIT_HI;
            TX_WAIT_HI: begin
                if (tx_ready) begin
                    if (bidx_q == BIW'(TX_BYTES)) state_d = TX_IDLE;
                    else begin
                        tx_data_d  = shift_q[TXW-1 -: 8];
                        shift_d    = shift_q << 8;
                        bidx_d     = bidx_q + BIW'(1);
                        tx_start_d = 1'b1;
                        state_d    = TX_START;
                    end
                end
            end
            default:    state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q        <= '0;
            frame_q      <= '0;
            to_q         <= '0;
            decode_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_d_q   <= '0;
            mem_wr_req_q <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_rd_num_q <= 6'd1;
            left_q       <= '0;
            rd_word_q    <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            burst_q      <= 1'b0;
            hold_v_q     <= 1'b0;
            err_count_q  <= '0;
            state_q      <= TX_IDLE;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            shift_q      <= '0;
            bidx_q       <= '0;
        end else begin
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            to_q         <= to_d;
            decode_q     <= decode_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_d_q   <= mem_wr_d_d;
            mem_wr_req_q <= mem_wr_req_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_rd_num_q <= mem_rd_num_d;
            left_q       <= left_d;
            rd_word_q    <= rd_word_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            burst_q      <= burst_d;
            hold_v_q     <= hold_v_d;
            err_count_q  <= err_count_d;
            state_q      <= state_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            shift_q      <= shift_d;
            bidx_q       <= bidx_d;
        end
    end

    hram_resp_fifo #(
        .DW    (DW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push_v),
        .push_data  (push_w),
        .pop        (pop),
        .pop_data_c (fifo_rd_c),
        .full_c     (full_c),
        .empty_c    (empty_c),
        .level      (fifo_level)
    );

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr_d   = mem_wr_d_q;
    assign mem_wr_req = mem_wr_req_q;
    assign mem_rd_req = mem_rd_req_q;
    assign mem_rd_num = mem_rd_num_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_hram_uart_cmd_bridge.sv
// Scoreboard bench for hram_uart_cmd_bridge: expected TX bytes are queued at stimulus time
// and a separate uart_tx model pops and compares each byte the bridge starts.
`timescale 1ns/1ps
module tb_hram_uart_cmd_bridge;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 200;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          rx_rcv = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          tx_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wr_d;
    logic          mem_wr_req, mem_rd_req;
    logic [5:0]    mem_rd_num;
    logic [DW-1:0] mem_rd_d = '0;
    logic          mem_rd_rdy = 1'b0;
    logic          mem_busy = 1'b0;
    logic [7:0]    err_count;

    int total = 0;
    int bad = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    logic [7:0] exp_q[$];

    hram_uart_cmd_bridge #(
        .DW             (DW),
        .DATA_BYTES     (DW / 8),
        .RESP_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_rcv     (rx_rcv),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .mem_addr   (mem_addr),
        .mem_wr_d   (mem_wr_d),
        .mem_wr_req (mem_wr_req),
        .mem_rd_req (mem_rd_req),
        .mem_rd_num (mem_rd_num),
        .mem_rd_d   (mem_rd_d),
        .mem_rd_rdy (mem_rd_rdy),
        .mem_busy   (mem_busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // uart_tx model and scoreboard monitor
    initial begin
        logic [7:0] e;
        tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected: got byte %02h with nothing expected", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 64'(tx_data), 64'(e));
                end
                tx_ready = 1'b0;
                repeat (3) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_wr_req === 1'b1) wr_pulses++;
        if (mem_rd_req === 1'b1) rd_pulses++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rcv  = 1'b1;
        @(negedge clk);
        rx_rcv  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c, input logic [31:0] p);
        send_byte(c);
        send_byte(p[31:24]);
        send_byte(p[23:16]);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
`ifdef HRAM_CMD_CKSUM_EN
        send_byte(c ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0]);
`endif
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
`ifdef HRAM_CMD_CKSUM_EN
        exp_q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (20) @(negedge clk);
    endtask

    task automatic feed_burst(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3, input int n);
        logic [31:0] ws [4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_rd_rdy = 1'b1;
            mem_rd_d   = ws[i];
            expect_word(ws[i]);
        end
        @(negedge clk);
        mem_rd_rdy = 1'b0;
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 64'(tx_start), 64'd0);
        chk("rst_rd_num", 64'(mem_rd_num), 64'd1);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_wr_req", 64'(mem_wr_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // address echo then counter sequence
        expect_word(32'h0000_0010);
        send_cmd(8'h01, 32'h0000_0010);
        for (int i = 0; i < 4; i++) begin
            expect_word(32'(i));
            send_cmd(8'h06, 32'h0);
        end
        wait_drain("drain_addr_count");
        chk("mem_addr", 64'(mem_addr), 64'h10);

        // load and write
        expect_word(32'hDEAD_BEEF);
        send_cmd(8'h02, 32'hDEAD_BEEF);
        expect_word(32'd3);
        send_cmd(8'h03, 32'h0);
        wait_drain("drain_write");
        chk("wr_pulses", 64'(wr_pulses), 64'd1);
        chk("mem_wr_d", 64'(mem_wr_d), 64'hDEAD_BEEF);
        expect_word(32'd259);
        send_cmd(8'h07, 32'h0);
        wait_drain("drain_const");

        // four-word burst read
        base = rd_pulses;
        send_cmd(8'h08, 32'h0000_0004);
        for (int i = 0; i < 50 && rd_pulses == base; i++) @(negedge clk);
        chk("burst_rd_req", 64'(rd_pulses - base), 64'd1);
        chk("burst_rd_num", 64'(mem_rd_num), 64'd4);
        feed_burst(32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00, 4);
        wait_drain("drain_burst");
        expect_word(32'hDDEE_FF00);
        send_cmd(8'h04, 32'h0);
        base = rd_pulses;
        expect_word(32'd5);
        send_cmd(8'h05, 32'h0);
        wait_drain("drain_read_rdreq");
        chk("rdreq_pulse", 64'(rd_pulses - base), 64'd1);
        chk("rdreq_num", 64'(mem_rd_num), 64'd1);
        chk("err_clean", 64'(err_count), 64'd0);

        // NAK cases
        base = rd_pulses;
        expect_word(32'hEEEE_EEEE);
        send_cmd(8'h08, 32'h0);
        expect_word(32'hEEEE_EEEE);
        send_cmd(8'h42, 32'h1234_5678);
        mem_busy = 1'b1;
        expect_word(32'hEEEE_EEEE);
        send_cmd(8'h05, 32'h0);
        wait_drain("drain_nak");
        chk("nak_err3", 64'(err_count), 64'd3);
        chk("nak_no_rd_req", 64'(rd_pulses - base), 64'd0);
        expect_word(32'hEEEE_EEEE);
        send_cmd(8'h08, 32'h0000_0009);
        wait_drain("drain_nak_n9");
        chk("nak_err4", 64'(err_count), 64'd4);
        expect_word(32'h0000_0101);
        send_cmd(8'h09, 32'h0);
        wait_drain("drain_status");
        mem_busy = 1'b0;

        // reset in the middle of a burst transmission
        send_cmd(8'h08, 32'h0000_0002);
        feed_burst(32'hCAFE_F00D, 32'h0BAD_C0DE, 32'h0, 32'h0, 2);
        for (int i = 0; i < 500 && exp_q.size() == 8; i++) @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_tx_start", 64'(tx_start), 64'd0);
        chk("mid_rst_err", 64'(err_count), 64'd0);
        chk("mid_rst_rd_num", 64'(mem_rd_num), 64'd1);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        repeat (8) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        expect_word(32'h0);
        send_cmd(8'h09, 32'h0);
        expect_word(32'd259);
        send_cmd(8'h07, 32'h0);
        wait_drain("drain_after_rst");

        // partial frame dropped by inter-byte timeout
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO + 20) @(negedge clk);
        chk("timeout_err", 64'(err_count), 64'd1);
        expect_word(32'h0000_0103);
        send_cmd(8'h07, 32'h0);
        wait_drain("drain_timeout");
        chk("timeout_addr", 64'(mem_addr), 64'd0);
        chk("timeout_err_final", 64'(err_count), 64'd1);

        repeat (30) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
